// File: rtl/reg_file_forwarding.sv
// reg_file_forwarding: 8x16 register file, two write ports, two combinational read ports
// with write-through forwarding; write port 2 wins on address conflicts.
module reg_file_forwarding #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3,
    parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] write_addr1,
    input  logic [DATA_WIDTH-1:0] write_data1,
    input  logic                  we2,
    input  logic [ADDR_WIDTH-1:0] write_addr2,
    input  logic [DATA_WIDTH-1:0] write_data2,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Port 2 is assigned last so it overrides port 1 on a shared address.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            if (we1) regs[write_addr1] <= write_data1;
            if (we2) regs[write_addr2] <= write_data2;
        end
    end

    always_comb begin
        read_data1 = !rst ? '0 :
                     (we2 && write_addr2 == read_addr1) ? write_data2 :
                     (we1 && write_addr1 == read_addr1) ? write_data1 : regs[read_addr1];
        read_data2 = !rst ? '0 :
                     (we2 && write_addr2 == read_addr2) ? write_data2 :
                     (we1 && write_addr1 == read_addr2) ? write_data1 : regs[read_addr2];
    end
endmodule

// File: tb/tb_reg_file_forwarding.sv
// tb_reg_file_forwarding: directed vectors; expectations queued by stimulus, compared by a monitor.
`timescale 1ns/1ps
module tb_reg_file_forwarding;
    logic        clk = 0;
    logic        rst = 0;
    logic        we1 = 0, we2 = 0;
    logic [2:0]  write_addr1 = 0, write_addr2 = 0, read_addr1 = 0, read_addr2 = 0;
    logic [15:0] write_data1 = 0, write_data2 = 0;
    logic [15:0] read_data1, read_data2;

    int compared = 0;
    int mismatched = 0;
    int issued = 0;
    logic [15:0] q1[$], q2[$];
    string qn[$];
    event smp;

    reg_file_forwarding dut (
        .clk(clk), .rst(rst),
        .we1(we1), .write_addr1(write_addr1), .write_data1(write_data1),
        .we2(we2), .write_addr2(write_addr2), .write_data2(write_data2),
        .read_addr1(read_addr1), .read_addr2(read_addr2),
        .read_data1(read_data1), .read_data2(read_data2)
    );

    always #10 clk = ~clk;

    task automatic chk(input string nm, input logic [15:0] e1, input logic [15:0] e2);
        #1;
        qn.push_back(nm);
        q1.push_back(e1);
        q2.push_back(e2);
        issued++;
        ->smp;
        #1;
    endtask

    initial begin
        logic [15:0] e1, e2;
        string nm;
        forever begin
            @(smp);
            while (q1.size() != 0) begin
                e1 = q1.pop_front();
                e2 = q2.pop_front();
                nm = qn.pop_front();
                compared++;
                if (read_data1 !== e1 || read_data2 !== e2) begin
                    mismatched++;
                    $display("FAIL %s: got rd1=%h rd2=%h, expected rd1=%h rd2=%h",
                             nm, read_data1, read_data2, e1, e2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with enables and forwarding conditions active
        we1 = 1; we2 = 1;
        write_addr1 = 3'd0; write_addr2 = 3'd1;
        write_data1 = 16'($urandom); write_data2 = 16'($urandom);
        read_addr1 = 3'd0; read_addr2 = 3'd1;
        @(negedge clk);
        chk("reset_fwd_blocked", 16'h0000, 16'h0000);
        @(negedge clk);
        write_addr1 = 3'd2; write_addr2 = 3'd3;
        chk("reset_fwd_blocked2", 16'h0000, 16'h0000);
        @(negedge clk);
        we1 = 0; we2 = 0; rst = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            read_addr1 = 3'(i); read_addr2 = 3'(7 - i);
            chk($sformatf("reset_R%0d", i), 16'h0000, 16'h0000);
        end

        // Port-1 forward and commit
        @(negedge clk);
        we1 = 1; write_addr1 = 3'd1; write_data1 = 16'hAAAA; read_addr1 = 3'd1; read_addr2 = 3'd0;
        chk("p1_forward", 16'hAAAA, 16'h0000);
        @(negedge clk);
        we1 = 0;
        chk("p1_commit", 16'hAAAA, 16'h0000);

        // Port-2 forward and commit
        we2 = 1; write_addr2 = 3'd2; write_data2 = 16'hBBBB; read_addr2 = 3'd2;
        chk("p2_forward", 16'hAAAA, 16'hBBBB);
        @(negedge clk);
        we2 = 0;
        chk("p2_commit", 16'hAAAA, 16'hBBBB);

        // Same-address conflict: port 2 wins
        we1 = 1; we2 = 1; write_addr1 = 3'd3; write_addr2 = 3'd3;
        write_data1 = 16'h1234; write_data2 = 16'h5678; read_addr1 = 3'd3; read_addr2 = 3'd3;
        chk("conflict_forward", 16'h5678, 16'h5678);
        @(negedge clk);
        we1 = 0; we2 = 0;
        chk("conflict_commit", 16'h5678, 16'h5678);

        // Stable read-back, no false forwarding
        read_addr1 = 3'd1; read_addr2 = 3'd2;
        chk("readback", 16'hAAAA, 16'hBBBB);
        we1 = 1; write_addr1 = 3'd4; write_data1 = 16'hFFFF;
        chk("no_false_fwd", 16'hAAAA, 16'hBBBB);
        read_addr1 = 3'd4;
        chk("fwd_R4", 16'hFFFF, 16'hBBBB);
        we1 = 0; write_data1 = 16'h1111;
        chk("disabled_write_fwd", 16'h0000, 16'hBBBB);
        read_addr1 = 3'd1;
        @(negedge clk);
        chk("disabled_data_change", 16'hAAAA, 16'hBBBB);

        // Cross-port forwarding, then mid-cycle reset
        we1 = 1; write_addr1 = 3'd5; write_data1 = 16'h0F0F; read_addr2 = 3'd5;
        chk("cross_fwd_p1", 16'hAAAA, 16'h0F0F);
        we2 = 1; write_addr2 = 3'd5; write_data2 = 16'hF0F0;
        chk("cross_fwd_p2_wins", 16'hAAAA, 16'hF0F0);
        rst = 0;
        chk("midcycle_reset", 16'h0000, 16'h0000);
        @(negedge clk);
        we1 = 0; we2 = 0; rst = 1;
        read_addr1 = 3'd5; read_addr2 = 3'd1;
        chk("reset_beats_write", 16'h0000, 16'h0000);
        read_addr1 = 3'd3; read_addr2 = 3'd2;
        chk("reset_cleared", 16'h0000, 16'h0000);

        // First write after reset release
        we2 = 1; write_addr2 = 3'd7; write_data2 = 16'hC3C3; read_addr1 = 3'd0; read_addr2 = 3'd0;
        @(negedge clk);
        we2 = 0; read_addr1 = 3'd7;
        chk("post_reset_write", 16'hC3C3, 16'h0000);

        #5;
        if (q1.size() != 0 || compared != issued) begin
            mismatched++;
            $display("FAIL scoreboard_drain: compared %0d, expected %0d", compared, issued);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
